// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - Shared AXI burst/response codes and bridge state encoding
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/axi_burst_addr_next.sv
// rtl/axi_burst_addr_next.sv - Combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_next
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_ok;

  // Beat stride, wrap window, then pick the advance rule; illegal wrap lengths and
  // the reserved burst code fall through to INCR behaviour
  always_comb begin
    incr      = ADDR_WIDTH'(1) << size_i;
    wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
    wrap_ok   = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    next_addr_o = (addr_i & ~(incr - ADDR_WIDTH'(1))) + incr;
    if (burst_i == AXI_BURST_FIXED) begin
      next_addr_o = addr_i;
    end else if ((burst_i == AXI_BURST_WRAP) && wrap_ok) begin
      next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + incr) & wrap_mask);
    end
  end

endmodule

// File: rtl/axi_axil_adapter_wr.sv
// rtl/axi_axil_adapter_wr.sv - Splits AXI4 write bursts into single-beat AXI-lite writes
module axi_axil_adapter_wr
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready
);

  bridge_state_e         state_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [2:0]            prot_q;
  logic [ADDR_WIDTH-1:0] m_awaddr_q;
  logic                  m_awvalid_q;
  logic [DATA_WIDTH-1:0] m_wdata_q;
  logic [STRB_WIDTH-1:0] m_wstrb_q;
  logic                  m_wvalid_q;
  logic                  m_bready_q;
  logic [ADDR_WIDTH-1:0] addr_next_d;

  // Beat count is taken from awlen alone, so wlast carries no information here
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;

  axi_burst_addr_next #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_next (
    .addr_i     (addr_q),
    .size_i     (size_q),
    .len_i      (len_q),
    .burst_i    (burst_q),
    .next_addr_o(addr_next_d)
  );

  // Burst sequencer: accept one AW, issue one AXI-lite write per beat, merge the responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= AXI_RESP_OKAY;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      prot_q      <= '0;
      m_awaddr_q  <= '0;
      m_awvalid_q <= 1'b0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      m_wvalid_q  <= 1'b0;
      m_bready_q  <= 1'b0;
    end else begin
      if (m_awvalid_q && m_axil_awready) m_awvalid_q <= 1'b0;
      if (m_wvalid_q && m_axil_wready)   m_wvalid_q  <= 1'b0;
      if (bvalid_q && s_axi_bready)      bvalid_q    <= 1'b0;

      case (state_q)
        IDLE: begin
          if (awready_q && s_axi_awvalid) begin
            bid_q     <= s_axi_awid;
            addr_q    <= s_axi_awaddr;
            len_q     <= s_axi_awlen;
            cnt_q     <= s_axi_awlen;
            size_q    <= s_axi_awsize;
            burst_q   <= s_axi_awburst;
            prot_q    <= s_axi_awprot;
            bresp_q   <= AXI_RESP_OKAY;
            awready_q <= 1'b0;
            state_q   <= DATA;
          end else begin
            awready_q <= !bvalid_q && !m_awvalid_q;
          end
        end
        DATA: begin
          if (wready_q && s_axi_wvalid) begin
            m_awaddr_q  <= addr_q;
            m_wdata_q   <= s_axi_wdata;
            m_wstrb_q   <= s_axi_wstrb;
            m_awvalid_q <= 1'b1;
            m_wvalid_q  <= 1'b1;
            wready_q    <= 1'b0;
            m_bready_q  <= 1'b1;
            state_q     <= RESP;
          end else begin
            wready_q <= !m_wvalid_q;
          end
        end
        RESP: begin
          if (m_bready_q && m_axil_bvalid) begin
            m_bready_q <= 1'b0;
            if (m_axil_bresp > bresp_q) bresp_q <= m_axil_bresp;
            if (cnt_q == 8'd0) begin
              bvalid_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              cnt_q   <= cnt_q - 8'd1;
              addr_q  <= addr_next_d;
              state_q <= DATA;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axi_awready  = awready_q;
  assign s_axi_wready   = wready_q;
  assign s_axi_bid      = bid_q;
  assign s_axi_bresp    = bresp_q;
  assign s_axi_bvalid   = bvalid_q;
  assign m_axil_awaddr  = m_awaddr_q;
  assign m_axil_awprot  = prot_q;
  assign m_axil_awvalid = m_awvalid_q;
  assign m_axil_wdata   = m_wdata_q;
  assign m_axil_wstrb   = m_wstrb_q;
  assign m_axil_wvalid  = m_wvalid_q;
  assign m_axil_bready  = m_bready_q;

endmodule
